dip_line_window: RTL and testbench

DIP_LINE_WINDOW -- requirements
Module: dip_line_window

---
 rtl/dip_line_window.sv | 225 ++++++++++++++++++++++
 tb/tb_dip_line_window.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dip_line_window.sv
// Sliding N x N pixel window over a raster stream, fed by N-1 line-buffer rows.
// Optional line-length checker is compiled in with `define DIP_LINE_WINDOW_LINE_CHECK_EN.
module dip_line_window #(
  parameter int PRA_VALUE_WIDTH = 8,
  parameter int PRA_WINDOW_SIZE = 5,
  parameter int PRA_MAX_LINE    = 2048,
  parameter int PRA_CNT_WIDTH   = 12
) (
  input  logic                                                       i_clk,
  input  logic                                                       i_rst,
  input  logic                                                       i_vs,
  input  logic                                                       i_hs,
  input  logic [PRA_VALUE_WIDTH-1:0]                                 i_data,
  output logic                                                       o_vs,
  output logic                                                       o_hs,
  output logic                                                       o_en,
  output logic [PRA_WINDOW_SIZE*PRA_WINDOW_SIZE*PRA_VALUE_WIDTH-1:0] o_window,
  output logic [PRA_CNT_WIDTH-1:0]                                   o_x,
  output logic [PRA_CNT_WIDTH-1:0]                                   o_y,
  output logic                                                       o_line_err
);

  localparam int W  = PRA_VALUE_WIDTH;
  localparam int N  = PRA_WINDOW_SIZE;
  localparam int CW = PRA_CNT_WIDTH;
  localparam int AW = (PRA_MAX_LINE > 1) ? $clog2(PRA_MAX_LINE) : 1;
  localparam logic [CW-1:0] EDGE_IDX = CW'(N - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(PRA_MAX_LINE - 1);
  localparam logic [CW-1:0] ROW_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic            vs_q, vs_d;
  logic            hs_q, hs_d;
  logic            vs_low_q, vs_low_d;
  logic            act_q, act_d;
  logic            line_q, line_d;
  logic            en_q, en_d;
  logic [CW-1:0]   col_q, col_d;
  logic [CW-1:0]   row_q, row_d;
  logic [CW-1:0]   x_q, x_d;
  logic [CW-1:0]   y_q, y_d;
  logic [N*N*W-1:0] win_q, win_d;

  logic            vs_rise;
  logic            accept;
  logic            line_end;
  logic [CW-1:0]   x_pix;
  logic [CW-1:0]   y_pix;
  logic [AW-1:0]   addr;

  logic [W-1:0]    lb_mem [N-1][PRA_MAX_LINE];
  logic [W-1:0]    lb_rd  [N-1];
  logic [W-1:0]    col_new [N];

  // vs_low_q starts at 0 so a frame already in progress at reset release is skipped.
  always_comb begin
    vs_rise  = i_vs & vs_low_q;
    accept   = i_hs & i_vs & (act_q | vs_rise);
    line_end = line_q & ~accept;
    x_pix    = vs_rise ? '0 : col_q;
    y_pix    = vs_rise ? '0 : row_q;
    addr     = x_pix[AW-1:0];
  end

  // Asynchronous read keeps the window one cycle behind the accepted pixel.
  always_comb begin
    for (int k = 0; k < N-1; k++) begin
      lb_rd[k] = lb_mem[k][addr];
    end
    col_new[N-1] = i_data;
    for (int k = 0; k < N-1; k++) begin
      col_new[N-2-k] = (y_pix > CW'(k)) ? lb_rd[k] : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept && !i_rst) begin
      lb_mem[0][addr] <= i_data;
      for (int k = 1; k < N-1; k++) begin
        lb_mem[k][addr] <= lb_rd[k-1];
      end
    end
  end

  always_comb begin
    vs_d     = i_vs;
    hs_d     = i_hs;
    vs_low_d = ~i_vs;
    line_d   = accept;

    act_d = act_q;
    if (vs_rise) begin
      act_d = 1'b1;
    end else if (!i_vs) begin
      act_d = 1'b0;
    end

    col_d = col_q;
    if (vs_rise || line_end) begin
      col_d = '0;
    end
    if (accept) begin
      col_d = (x_pix == LAST_COL) ? x_pix : x_pix + ONE;
    end

    row_d = row_q;
    if (vs_rise) begin
      row_d = '0;
    end else if (line_end && (row_q != ROW_MAX)) begin
      row_d = row_q + ONE;
    end

    x_d  = accept ? x_pix : x_q;
    y_d  = accept ? y_pix : y_q;
    en_d = accept && (x_pix >= EDGE_IDX) && (y_pix >= EDGE_IDX);

    // Column 0 is the oldest; the new column enters at N-1.
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N-1; c++) begin
          win_d[(r*N+c)*W +: W] = win_q[(r*N+c+1)*W +: W];
        end
        win_d[(r*N+N-1)*W +: W] = col_new[r];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_q     <= 1'b0;
      hs_q     <= 1'b0;
      vs_low_q <= 1'b0;
      act_q    <= 1'b0;
      line_q   <= 1'b0;
      en_q     <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      win_q    <= '0;
    end else begin
      vs_q     <= vs_d;
      hs_q     <= hs_d;
      vs_low_q <= vs_low_d;
      act_q    <= act_d;
      line_q   <= line_d;
      en_q     <= en_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x_q      <= x_d;
      y_q      <= y_d;
      win_q    <= win_d;
    end
  end

  assign o_vs     = vs_q;
  assign o_hs     = hs_q;
  assign o_en     = en_q;
  assign o_window = win_q;
  assign o_x      = x_q;
  assign o_y      = y_q;

`ifdef DIP_LINE_WINDOW_LINE_CHECK_EN
  localparam logic [CW-1:0] FULL_LEN = CW'(PRA_MAX_LINE);

  logic          sat_q, sat_d;
  logic          first_q, first_d;
  logic          err_q, err_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] line_len;

  // sat_q marks that the last address was written, so a further pixel overflows.
  always_comb begin
    line_len = sat_q ? FULL_LEN : col_q;
    sat_d    = sat_q;
    first_d  = first_q;
    len_d    = len_q;
    err_d    = err_q;

    if (vs_rise || line_end) begin
      sat_d = 1'b0;
    end
    if (accept && sat_q && !vs_rise) begin
      err_d = 1'b1;
    end
    if (accept && (x_pix == LAST_COL)) begin
      sat_d = 1'b1;
    end

    if (line_end) begin
      if (!first_q) begin
        first_d = 1'b1;
        len_d   = line_len;
      end else if (line_len != len_q) begin
        err_d = 1'b1;
      end
    end

    if (vs_rise) begin
      first_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sat_q   <= 1'b0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      sat_q   <= sat_d;
      first_q <= first_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

  assign o_line_err = err_q;
`else
  assign o_line_err = 1'b0;
`endif

endmodule

// File: tb/tb_dip_line_window.sv
// Directed bench for dip_line_window: a 3x3 instance with 16-pixel lines and a default-sized 5x5 instance.
// Expected values come from the pixel pattern 16*y+x and hand-worked traces.
module tb_dip_line_window;

  logic        clk = 1'b0;
  logic        rst;
  logic        vs;
  logic        hs;
  logic [7:0]  data;

  logic        o_vs3, o_hs3, o_en3, err3;
  logic [71:0] win3;
  logic [4:0]  x3, y3;

  logic        o_vs5, o_hs5, o_en5, err5;
  logic [199:0] win5;
  logic [11:0] x5, y5;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DIP_LINE_WINDOW_LINE_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  dip_line_window #(
    .PRA_VALUE_WIDTH(8), .PRA_WINDOW_SIZE(3), .PRA_MAX_LINE(16), .PRA_CNT_WIDTH(5)
  ) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_vs(vs), .i_hs(hs), .i_data(data),
    .o_vs(o_vs3), .o_hs(o_hs3), .o_en(o_en3), .o_window(win3),
    .o_x(x3), .o_y(y3), .o_line_err(err3)
  );

  dip_line_window #(
    .PRA_VALUE_WIDTH(8), .PRA_WINDOW_SIZE(5)
  ) u_dut5 (
    .i_clk(clk), .i_rst(rst), .i_vs(vs), .i_hs(hs), .i_data(data),
    .o_vs(o_vs5), .o_hs(o_hs5), .o_en(o_en5), .o_window(win5),
    .o_x(x5), .o_y(y5), .o_line_err(err5)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs; return 1 time unit after the sampling edge.
  task automatic cyc(input logic v, input logic h, input logic [7:0] d);
    vs   = v;
    hs   = h;
    data = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] elem3(input logic [71:0] w, input int r, input int c);
    return w[(r*3+c)*8 +: 8];
  endfunction

  // Full frame into the 3x3 instance with pixel = 16*y + x.
  task automatic run_frame(input int lines, input int pix, input bit merged, input string tag);
    logic [71:0] exp_w;
    int          en_n;
    int          exp_en_n;
    bit          seen;
    en_n = 0;
    seen = 1'b0;
    exp_en_n = (lines > 2 && pix > 2) ? (lines - 2) * (pix - 2) : 0;
    cyc(1'b0, 1'b0, 8'h00);
    if (!merged) cyc(1'b1, 1'b0, 8'h00);
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < pix; x++) begin
        cyc(1'b1, 1'b1, 8'(16*y + x));
        check({tag, "_hs"}, o_hs3, 1);
        check({tag, "_x"}, x3, x);
        check({tag, "_y"}, y3, y);
        check({tag, "_en"}, o_en3, (x >= 2 && y >= 2));
        if (o_en3) en_n++;
        if (o_en3 && !seen) begin
          seen = 1'b1;
          check({tag, "_first_x"}, x3, 2);
          check({tag, "_first_y"}, y3, 2);
          check({tag, "_first_e00"}, elem3(win3, 0, 0), 8'h00);
          check({tag, "_first_e22"}, elem3(win3, 2, 2), 8'h22);
        end
        if (x >= 2) begin
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              exp_w[(r*3+c)*8 +: 8] = (y - 2 + r >= 0) ? 8'(16*(y-2+r) + x - 2 + c) : 8'h00;
          check({tag, "_win"}, win3, exp_w);
        end
      end
      cyc(1'b1, 1'b0, 8'h00);
      check({tag, "_eol_hs"}, o_hs3, 0);
      check({tag, "_eol_en"}, o_en3, 0);
    end
    check({tag, "_en_count"}, en_n, exp_en_n);
    check({tag, "_en_seen"}, seen, (exp_en_n > 0));
    check({tag, "_err"}, err3, 0);
  endtask

  initial begin
    rst = 1'b1;
    vs = 1'b1; hs = 1'b1; data = 8'hFF;
    cyc(1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, 8'hFF);
    check("rst_vs", o_vs3, 0);
    check("rst_hs", o_hs3, 0);
    check("rst_en", o_en3, 0);
    check("rst_err", err3, 0);
    check("rst_x", x3, 0);
    check("rst_y", y3, 0);
    check("rst_win", win3, 0);
    check("rst_win5", win5, 0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);

    // Clean 8x4 frame, then one where the first pixel shares the i_vs rising cycle.
    run_frame(4, 8, 1'b0, "f1");
    run_frame(4, 8, 1'b1, "f2");

    // Reset mid-frame: everything clears, remaining pixels of that frame are ignored.
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    for (int x = 0; x < 5; x++) cyc(1'b1, 1'b1, 8'(x));
    cyc(1'b1, 1'b0, 8'h00);
    for (int x = 0; x < 3; x++) cyc(1'b1, 1'b1, 8'(8'h10 + x));
    rst = 1'b1;
    cyc(1'b1, 1'b1, 8'h55);
    rst = 1'b0;
    check("mrst_vs", o_vs3, 0);
    check("mrst_hs", o_hs3, 0);
    check("mrst_en", o_en3, 0);
    check("mrst_x", x3, 0);
    check("mrst_y", y3, 0);
    check("mrst_win", win3, 0);
    cyc(1'b1, 1'b1, 8'h66);
    check("post_rst_hs", o_hs3, 1);
    check("post_rst_x", x3, 0);
    check("post_rst_win", win3, 0);
    cyc(1'b1, 1'b0, 8'h00);
    run_frame(4, 8, 1'b0, "f3");

    // Idle cycle inside an i_hs run: window holds, o_en low, run splits into two lines.
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    for (int x = 0; x < 4; x++) cyc(1'b1, 1'b1, 8'(8'h10 + x));
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h20);
    cyc(1'b1, 1'b1, 8'h21);
    cyc(1'b1, 1'b0, 8'h00);
    check("gap_hs", o_hs3, 0);
    check("gap_en", o_en3, 0);
    check("gap_x", x3, 1);
    check("gap_y", y3, 1);
    check("gap_e22", elem3(win3, 2, 2), 8'h21);
    check("gap_e12", elem3(win3, 1, 2), 8'h11);
    check("gap_e20", elem3(win3, 2, 0), 8'h13);
    check("gap_e02", elem3(win3, 0, 2), 8'h00);
    cyc(1'b1, 1'b1, 8'h22);
    check("gap_next_x", x3, 0);
    check("gap_next_y", y3, 2);
    check("gap_next_en", o_en3, 0);
    cyc(1'b1, 1'b1, 8'h23);
    cyc(1'b1, 1'b0, 8'h00);

    // Line lengths 8, 8, 7.
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    for (int l = 0; l < 3; l++) begin
      for (int x = 0; x < ((l == 2) ? 7 : 8); x++) cyc(1'b1, 1'b1, 8'(x));
      cyc(1'b1, 1'b0, 8'h00);
      check($sformatf("len_err_l%0d", l), err3, (l == 2) ? ERR_ON : 1'b0);
    end
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    check("len_err_clear", err3, 0);

    // 5x5 instance with 4-pixel lines never produces a window.
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    for (int l = 0; l < 6; l++) begin
      for (int x = 0; x < 4; x++) begin
        cyc(1'b1, 1'b1, 8'(16*l + x));
        check("n5_hs", o_hs5, 1);
        check("n5_en", o_en5, 0);
      end
      cyc(1'b1, 1'b0, 8'h00);
      check("n5_hs_low", o_hs5, 0);
    end
    check("n5_y", y5, 5);
    check("n5_x", x5, 3);

    // 20-pixel line into a 16-deep buffer: column holds at 15, no wrap into column 0.
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    for (int x = 0; x < 20; x++) begin
      cyc(1'b1, 1'b1, 8'(x));
      check("max_x", x3, (x > 15) ? 15 : x);
    end
    cyc(1'b1, 1'b0, 8'h00);
    check("max_err", err3, ERR_ON);
    for (int x = 0; x < 3; x++) cyc(1'b1, 1'b1, 8'(8'hA0 + x));
    check("wrap_e10", elem3(win3, 1, 0), 8'h00);
    check("wrap_e11", elem3(win3, 1, 1), 8'h01);
    check("wrap_e12", elem3(win3, 1, 2), 8'h02);
    check("wrap_e22", elem3(win3, 2, 2), 8'hA2);
    check("wrap_e02", elem3(win3, 0, 2), 8'h00);
    check("wrap_y", y3, 1);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
